attack_controller: RTL and testbench

ATTACK_CONTROLLER -- requirements
Module: attack_controller

---
 rtl/attack_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_attack_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_controller.sv
// attack_controller
//   Round controller for a grid "battleship" game. A round starts by loading
//   a ship map. Each rising edge of confirmAttack fires one shot at
//   (x_coord_code, y_coord_code). The shot is classified one cycle later as
//   invalid, repeat, hit or miss. The round ends with a win when every ship
//   cell has been hit, or with a loss when the shots run out.
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   enable            low freezes all state and ignores start/confirmAttack
//   start             level; (re)loads selected_map and begins a round
//   selected_map      ship map, bit (x*ROWS+y) = ship at column x, row y
//   x/y_coord_code    zero-based attack coordinates
//   confirmAttack     attack request, rising edge only
//   matriz_data       hit cells while playing, full ship map once over
//   ledRgb            [0] miss, [1] hit, [2] repeat/invalid
//   hit_count         hits scored in the current round
//   shots_left        shots remaining in the current round
//   game_over, win    round status
//   busy              high while a shot is being resolved
module attack_controller #(
  parameter int ROWS       = 7,
  parameter int COLS       = 5,
  parameter int DATA_WIDTH = ROWS * COLS,
  parameter int COORD_W    = 3,
  parameter int MAX_SHOTS  = 15,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] selected_map,
  input  logic [COORD_W-1:0]    x_coord_code,
  input  logic [COORD_W-1:0]    y_coord_code,
  input  logic                  confirmAttack,
  output logic [DATA_WIDTH-1:0] matriz_data,
  output logic [2:0]            ledRgb,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      shots_left,
  output logic                  game_over,
  output logic                  win,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RESOLVE = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ship_map_q, ship_map_d;
  logic [DATA_WIDTH-1:0] shot_map_q, shot_map_d;
  logic [CNT_W-1:0]      ship_total_q, ship_total_d;
  logic [CNT_W-1:0]      hit_q, hit_d;
  logic [CNT_W-1:0]      shots_q, shots_d;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q, y_d;
  logic [2:0]            led_q, led_d;
  logic                  win_q, win_d;
  logic                  confirm_prev_q, confirm_prev_d;
  logic [DATA_WIDTH-1:0] matriz_q, matriz_d;
  logic                  game_over_q, game_over_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] cell_mask_s;
  logic                  cell_valid_s;
  logic                  cell_repeat_s;
  logic                  cell_hit_s;
  logic                  attack_edge_s;

  // Number of ship cells in a map.
  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  assign attack_edge_s = confirmAttack & ~confirm_prev_q;

  // One-hot mask of the latched shot cell. It is all zero when the
  // coordinates fall outside the grid, which doubles as the validity test.
  always_comb begin
    cell_mask_s = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        cell_mask_s[c*ROWS+r] = (x_q == COORD_W'(c)) && (y_q == COORD_W'(r));
      end
    end
    cell_valid_s  = |cell_mask_s;
    cell_repeat_s = |(cell_mask_s & shot_map_q);
    cell_hit_s    = |(cell_mask_s & ship_map_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    ship_map_d     = ship_map_q;
    shot_map_d     = shot_map_q;
    ship_total_d   = ship_total_q;
    hit_d          = hit_q;
    shots_d        = shots_q;
    x_d            = x_q;
    y_d            = y_q;
    led_d          = led_q;
    win_d          = win_q;
    confirm_prev_d = confirm_prev_q;

    if (enable) begin
      confirm_prev_d = confirmAttack;
      if (start) begin
        ship_map_d   = selected_map;
        shot_map_d   = '0;
        ship_total_d = popcount(selected_map);
        hit_d        = '0;
        shots_d      = CNT_W'(MAX_SHOTS);
        led_d        = 3'b000;
        win_d        = 1'b0;
        state_d      = PLAY;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          PLAY: begin
            // An empty map is won before any shot is taken.
            if (ship_total_q == '0) begin
              win_d   = 1'b1;
              state_d = OVER;
            end else if (attack_edge_s) begin
              x_d     = x_coord_code;
              y_d     = y_coord_code;
              state_d = RESOLVE;
            end else begin
              state_d = PLAY;
            end
          end
          RESOLVE: begin
            if (!cell_valid_s || cell_repeat_s) begin
              led_d   = 3'b100;
              state_d = PLAY;
            end else begin
              shot_map_d = shot_map_q | cell_mask_s;
              shots_d    = shots_q - CNT_W'(1);
              if (cell_hit_s) begin
                hit_d = hit_q + CNT_W'(1);
                led_d = 3'b010;
              end else begin
                led_d = 3'b001;
              end
              // Winning on the last shot counts as a win.
              if (hit_d == ship_total_q) begin
                win_d   = 1'b1;
                state_d = OVER;
              end else if (shots_d == '0) begin
                win_d   = 1'b0;
                state_d = OVER;
              end else begin
                state_d = PLAY;
              end
            end
          end
          OVER: begin
            state_d = OVER;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    // Outputs are derived from the next state so that they change on the
    // same edge as the state they describe.
    if (state_d == OVER) begin
      matriz_d = ship_map_d;
    end else begin
      matriz_d = shot_map_d & ship_map_d;
    end
    game_over_d = (state_d == OVER);
    busy_d      = (state_d == RESOLVE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      ship_map_q     <= '0;
      shot_map_q     <= '0;
      ship_total_q   <= '0;
      hit_q          <= '0;
      shots_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      led_q          <= 3'b000;
      win_q          <= 1'b0;
      confirm_prev_q <= 1'b0;
      matriz_q       <= '0;
      game_over_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ship_map_q     <= ship_map_d;
      shot_map_q     <= shot_map_d;
      ship_total_q   <= ship_total_d;
      hit_q          <= hit_d;
      shots_q        <= shots_d;
      x_q            <= x_d;
      y_q            <= y_d;
      led_q          <= led_d;
      win_q          <= win_d;
      confirm_prev_q <= confirm_prev_d;
      matriz_q       <= matriz_d;
      game_over_q    <= game_over_d;
      busy_q         <= busy_d;
    end
  end

  assign matriz_data = matriz_q;
  assign ledRgb      = led_q;
  assign hit_count   = hit_q;
  assign shots_left  = shots_q;
  assign game_over   = game_over_q;
  assign win         = win_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_attack_controller.sv
// Testbench for attack_controller: a small game model pushes the expected
// result of each attack into a queue when the attack is driven; the entry is
// popped and compared once the DUT has resolved the shot.
module tb_attack_controller;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int DW   = 35;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          start;
  logic [DW-1:0] selected_map;
  logic [2:0]    x_coord_code;
  logic [2:0]    y_coord_code;
  logic          confirmAttack;
  logic [DW-1:0] matriz_data;
  logic [2:0]    ledRgb;
  logic [5:0]    hit_count;
  logic [5:0]    shots_left;
  logic          game_over;
  logic          win;
  logic          busy;

  attack_controller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .selected_map (selected_map),
    .x_coord_code (x_coord_code),
    .y_coord_code (y_coord_code),
    .confirmAttack(confirmAttack),
    .matriz_data  (matriz_data),
    .ledRgb       (ledRgb),
    .hit_count    (hit_count),
    .shots_left   (shots_left),
    .game_over    (game_over),
    .win          (win),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    led;
    logic [5:0]    hits;
    logic [5:0]    shots;
    logic [DW-1:0] mat;
    logic          go;
    logic          won;
  } exp_t;

  exp_t sb_q[$];

  int checks_total;
  int checks_passed;

  // Game model.
  logic [DW-1:0] m_map;
  logic [DW-1:0] m_shot;
  int            m_hits;
  int            m_shots;
  int            m_total;
  logic [2:0]    m_led;
  logic          m_over;
  logic          m_win;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks_total++;
    if (obs !== exp_v) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.led   = m_led;
    e.hits  = 6'(m_hits);
    e.shots = 6'(m_shots);
    e.mat   = m_over ? m_map : (m_shot & m_map);
    e.go    = m_over;
    e.won   = m_win;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".led"},   64'(ledRgb),      64'(e.led));
    check({tag, ".hits"},  64'(hit_count),   64'(e.hits));
    check({tag, ".shots"}, 64'(shots_left),  64'(e.shots));
    check({tag, ".mat"},   64'(matriz_data), 64'(e.mat));
    check({tag, ".go"},    64'(game_over),   64'(e.go));
    check({tag, ".win"},   64'(win),         64'(e.won));
    check({tag, ".busy"},  64'(busy),        64'd0);
  endtask

  task automatic model_start(input logic [DW-1:0] map);
    m_map   = map;
    m_shot  = '0;
    m_hits  = 0;
    m_shots = 15;
    m_total = $countones(map);
    m_led   = 3'b000;
    m_over  = 1'b0;
    m_win   = 1'b0;
  endtask

  task automatic model_resolve(input int x, input int y);
    int idx;
    if (x >= COLS || y >= ROWS) begin
      m_led = 3'b100;
    end else begin
      idx = x * ROWS + y;
      if (m_shot[idx]) begin
        m_led = 3'b100;
      end else begin
        m_shot[idx] = 1'b1;
        m_shots--;
        if (m_map[idx]) begin
          m_hits++;
          m_led = 3'b010;
        end else begin
          m_led = 3'b001;
        end
        if (m_hits == m_total) begin
          m_over = 1'b1;
          m_win  = 1'b1;
        end else if (m_shots == 0) begin
          m_over = 1'b1;
          m_win  = 1'b0;
        end
      end
    end
    sb_q.push_back(model_now());
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_out(tag, e);
    end
  endtask

  task automatic do_start(input logic [DW-1:0] map);
    selected_map = map;
    start = 1'b1;
    model_start(map);
    tick();
    start = 1'b0;
  endtask

  task automatic attack(input string tag, input int x, input int y);
    x_coord_code  = 3'(x);
    y_coord_code  = 3'(y);
    confirmAttack = 1'b1;
    model_resolve(x, y);
    tick();
    check({tag, ".busy_resolve"}, 64'(busy), 64'd1);
    confirmAttack = 1'b0;
    tick();
    sb_pop_check(tag);
  endtask

  logic [DW-1:0] map_a;
  logic [DW-1:0] map_one;
  logic [2:0]    led_before;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset         = 1'b0;
    enable        = 1'b1;
    start         = 1'b0;
    selected_map  = '0;
    x_coord_code  = 3'd0;
    y_coord_code  = 3'd0;
    confirmAttack = 1'b0;
    model_start('0);
    m_shots = 0;

    // Reset state: everything zero.
    tick();
    check_out("reset", model_now());
    reset = 1'b1;

    // No activity before start, even with an attack edge.
    confirmAttack = 1'b1;
    tick();
    confirmAttack = 1'b0;
    tick();
    check_out("idle_attack", model_now());

    // Round with ships at bits 0 and 8.
    map_a = '0;
    map_a[0] = 1'b1;
    map_a[8] = 1'b1;
    do_start(map_a);
    check_out("start_a", model_now());
    attack("hit00", 0, 0);
    attack("rep00", 0, 0);
    attack("inv70", 7, 0);
    attack("win11", 1, 1);
    // Attack after game over is ignored.
    x_coord_code  = 3'd2;
    confirmAttack = 1'b1;
    tick();
    check("over_busy", 64'(busy), 64'd0);
    confirmAttack = 1'b0;
    tick();
    check_out("over_ignore", model_now());

    // Empty map: PLAY for one clock, then OVER with a win.
    do_start('0);
    check("zero_play_go", 64'(game_over), 64'd0);
    tick();
    m_over = 1'b1;
    m_win  = 1'b1;
    check_out("zero_over", model_now());

    // One ship; confirmAttack held high ten clocks is one shot.
    map_one = '0;
    map_one[34] = 1'b1;
    do_start(map_one);
    x_coord_code  = 3'd0;
    y_coord_code  = 3'd0;
    confirmAttack = 1'b1;
    model_resolve(0, 0);
    tick();
    check("hold_busy", 64'(busy), 64'd1);
    tick();
    sb_pop_check("hold_first");
    repeat (8) tick();
    confirmAttack = 1'b0;
    tick();
    check_out("hold_after", model_now());

    // enable low during RESOLVE freezes it.
    x_coord_code  = 3'd0;
    y_coord_code  = 3'd1;
    confirmAttack = 1'b1;
    led_before    = m_led;
    model_resolve(0, 1);
    tick();
    enable        = 1'b0;
    confirmAttack = 1'b0;
    repeat (3) tick();
    check("frozen_busy", 64'(busy), 64'd1);
    check("frozen_led", 64'(ledRgb), 64'(led_before));
    enable = 1'b1;
    tick();
    sb_pop_check("unfrozen");

    // Fifteen misses lose the round.
    do_start(map_one);
    for (int i = 0; i < 15; i++) begin
      attack($sformatf("miss%0d", i), i / ROWS, i % ROWS);
    end
    check("lose_shots", 64'(shots_left), 64'd0);
    check("lose_win", 64'(win), 64'd0);

    // Reset during RESOLVE clears everything and drops the shot.
    do_start(map_a);
    x_coord_code  = 3'd0;
    y_coord_code  = 3'd0;
    confirmAttack = 1'b1;
    tick();
    check("rst_pre_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    model_start('0);
    m_shots = 0;
    check_out("rst_async", model_now());
    tick();
    reset = 1'b1;
    repeat (3) tick();
    confirmAttack = 1'b0;
    tick();
    check_out("rst_idle", model_now());
    do_start(map_a);
    check_out("rst_restart", model_now());
    attack("rst_hit00", 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
